flash_fetch_unit: RTL and testbench

- SPI-flash instruction fetch stage directly downstream of the program counter.
- Takes the PC address, issues a standard READ (0x03) to an external serial flash, and shifts in one instruction word.
- Presents the word on instr_out and pulses flash_ready, which gates the PC's load/increment.
- One fetch in flight at a time; SPI mode 0.

---
 rtl/flash_fetch_unit_if.sv | 26 ++
 rtl/flash_fetch_unit.sv | 119 +++++++++++
 tb/tb_flash_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_fetch_unit_if.sv
// PC-side fetch handshake plus the serial-flash pins of the instruction fetch stage.
// The slave modport is the fetch unit; the master modport is the PC and flash side.
interface flash_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 16
);
  logic                   fetch_req;
  logic [ADDR_WIDTH-1:0]  fetch_addr;
  logic                   flash_ready;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   busy;
  logic                   spi_cs_n;
  logic                   spi_sck;
  logic                   spi_mosi;
  logic                   spi_miso;

  modport slave (
    input  fetch_req, fetch_addr, spi_miso,
    output flash_ready, instr_out, busy, spi_cs_n, spi_sck, spi_mosi
  );

  modport master (
    output fetch_req, fetch_addr, spi_miso,
    input  flash_ready, instr_out, busy, spi_cs_n, spi_sck, spi_mosi
  );
endinterface

// File: rtl/flash_fetch_unit.sv
// Fetches one instruction word from SPI flash (mode 0, READ opcode) per PC request.
// All SPI pins and handshake outputs are registered straight out of the FSM.
module flash_fetch_unit #(
  parameter int         ADDR_WIDTH  = 12,
  parameter int         INSTR_WIDTH = 16,
  parameter int         CLK_DIV     = 2,
  parameter logic [7:0] READ_CMD    = 8'h03
) (
  input  logic               clk,
  input  logic               arst,
  flash_fetch_unit_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(((INSTR_WIDTH > 24) ? INSTR_WIDTH : 24) + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(7);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(23);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(INSTR_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_e;

  state_e                 state_q;
  logic [DIV_W-1:0]       div_q;
  logic [BIT_W-1:0]       bit_q;
  logic [31:0]            tx_q;
  logic [INSTR_WIDTH-1:0] rx_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   cs_n_q;
  logic                   sck_q;
  logic                   mosi_q;
  logic                   ready_q;
  logic                   busy_q;

  logic [23:0] byte_addr;
  logic        phase_end;
  logic        last_bit;

  assign byte_addr = 24'(bus.fetch_addr) * 24'(INSTR_WIDTH / 8);
  assign phase_end = (div_q == DIV_LAST);
  assign last_bit  = (state_q == S_CMD)  ? (bit_q == CMD_LAST)  :
                     (state_q == S_ADDR) ? (bit_q == ADDR_LAST) :
                                           (bit_q == DATA_LAST);

  // NOTE: every register here is assigned with <= so all state advances together on
  // the edge; a blocking = would let later lines see this cycle's new values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      instr_q <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.fetch_req) begin
            state_q <= S_CMD;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            sck_q   <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            mosi_q  <= READ_CMD[7];
            tx_q    <= {READ_CMD[6:0], byte_addr, 1'b0};
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          div_q <= phase_end ? '0 : div_q + 1'b1;
          if (phase_end && !sck_q) begin
            // Rising SCK edge: the flash has held MISO stable since the falling edge.
            sck_q <= 1'b1;
            if (state_q == S_DATA) rx_q <= {rx_q[INSTR_WIDTH-2:0], bus.spi_miso};
          end else if (phase_end) begin
            sck_q  <= 1'b0;
            bit_q  <= last_bit ? '0 : bit_q + 1'b1;
            mosi_q <= tx_q[31];
            tx_q   <= {tx_q[30:0], 1'b0};
            if (last_bit) begin
              case (state_q)
                S_CMD:  state_q <= S_ADDR;
                S_ADDR: begin
                  state_q <= S_DATA;
                  mosi_q  <= 1'b0;
                end
                default: begin
                  state_q <= S_DONE;
                  cs_n_q  <= 1'b1;
                  instr_q <= rx_q;
                  ready_q <= 1'b1;
                end
              endcase
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.flash_ready = ready_q;
  assign bus.instr_out   = instr_q;
  assign bus.busy        = busy_q;
  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_sck     = sck_q;
  assign bus.spi_mosi    = mosi_q;

endmodule

// File: tb/tb_flash_fetch_unit.sv
// Bench for flash_fetch_unit: one instance at CLK_DIV=2 and one at CLK_DIV=1, each
// with a behavioural mode-0 flash model, an expected-result queue and a pin monitor.
module tb_flash_fetch_unit;

  localparam int AW = 12;
  localparam int IW = 16;

  typedef struct packed {
    logic [1:0]    inst;
    logic [31:0]   frame;
    logic [IW-1:0] word;
  } exp_t;

  typedef struct {
    int            inst;
    logic [AW-1:0] addr;
    logic [23:0]   baddr;
    logic [IW-1:0] word;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [1:0]         arst = 2'b11;
  logic [1:0]         req  = 2'b00;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0]         rdy, cs_n, sck, mosi, busy;
  logic [1:0][IW-1:0] instr;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [IW-1:0] flash_word(input logic [23:0] a);
    case (a)
      24'h000400: return 16'hA55A;
      24'h000402: return 16'h3C96;
      24'h001FFE: return 16'hBEEF;
      24'h000000: return 16'h1234;
      24'h000FFE: return 16'hC0DE;
      default:    return 16'hDEAD;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIVG = (g == 0) ? 2 : 1;
    localparam int LAT  = 1 + (64 + 2 * IW) * DIVG;

    flash_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    flash_fetch_unit #(
      .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .CLK_DIV(DIVG), .READ_CMD(8'h03)
    ) dut (
      .clk (clk),
      .arst(arst[g]),
      .bus (bus)
    );

    logic miso_r = 1'b0;
    assign bus.fetch_req  = req[g];
    assign bus.fetch_addr = addr[g];
    assign bus.spi_miso   = miso_r;
    assign rdy[g]   = bus.flash_ready;
    assign cs_n[g]  = bus.spi_cs_n;
    assign sck[g]   = bus.spi_sck;
    assign mosi[g]  = bus.spi_mosi;
    assign busy[g]  = bus.busy;
    assign instr[g] = bus.instr_out;

    // Flash model: latch opcode+address on rising SCK, drive data on falling SCK.
    int            bitn = 0;
    logic [31:0]   frame = '0;
    logic [31:0]   last_frame = '0;
    logic [IW-1:0] w;

    always @(negedge bus.spi_cs_n) begin
      bitn  = 0;
      frame = '0;
    end

    always @(posedge bus.spi_sck) begin
      if (bitn < 32) frame = {frame[30:0], bus.spi_mosi};
      bitn++;
      if (bitn == 32) last_frame = frame;
    end

    always @(negedge bus.spi_sck) begin
      if (!bus.spi_cs_n && bitn >= 32 && bitn < 32 + IW) begin
        w      = flash_word(frame[23:0]);
        miso_r = w[32 + IW - 1 - bitn];
      end
    end

    // Pin monitor and scoreboard consumer, sampled mid-cycle.
    int   ready_due = -1, cs_due = -1, run = 0, hi_cnt = 0, gap = 0, viol = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    exp_t e;

    always @(negedge clk) begin
      if (arst[g]) begin
        ready_due = -1;
        cs_due    = -1;
        prev_cs   = 1'b1;
        hi_cnt    = 0;
      end else begin
        if (req[g] && !busy[g]) begin
          cs_due    = cyc + 1;
          ready_due = cyc + LAT;
        end
        if (cyc == cs_due) check($sformatf("cs_fall[%0d]", g), cs_n[g], 1'b0);
        if (rdy[g]) begin
          if (sb.size() == 0) begin
            check($sformatf("unexpected_ready[%0d]", g), 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            check($sformatf("ready_inst[%0d]", g), 64'(g), 64'(e.inst));
            check($sformatf("ready_cycle[%0d]", g), 64'(cyc), 64'(ready_due));
            check($sformatf("frame[%0d]", g), last_frame, e.frame);
            check($sformatf("instr_out[%0d]", g), instr[g], e.word);
            check($sformatf("done_cs_high[%0d]", g), {cs_n[g], sck[g], busy[g]}, 3'b101);
          end
        end
        if (!cs_n[g] && !prev_cs) begin
          if (sck[g] == prev_sck) run++;
          else begin
            if (run != DIVG) viol++;
            run = 1;
          end
          if (prev_sck && sck[g] && mosi[g] != prev_mosi) viol++;
        end else if (!cs_n[g]) begin
          run = 1;
        end
        if (cs_n[g] && (sck[g] || mosi[g])) viol++;
        if (!cs_n[g] && mosi[g] && (bitn >= 33 || (bitn == 32 && !sck[g]))) viol++;
        if (cs_n[g]) hi_cnt++;
        else if (prev_cs) begin
          gap    = hi_cnt;
          hi_cnt = 0;
        end
        prev_cs   = cs_n[g];
        prev_sck  = sck[g];
        prev_mosi = mosi[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int g);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy[g]) break;
    end
    check($sformatf("accept[%0d]", g), busy[g], 1'b1);
  endtask

  task automatic wait_drain(input int g);
    for (int i = 0; i < 1000; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check($sformatf("drain[%0d]", g), 64'(sb.size()), 64'd0);
    repeat (3) tick();
    check($sformatf("busy_idle[%0d]", g), busy[g], 1'b0);
  endtask

  task automatic push_exp(input int g, input logic [23:0] ba, input logic [IW-1:0] wd);
    exp_t x;
    x.inst  = 2'(g);
    x.frame = {8'h03, ba};
    x.word  = wd;
    sb.push_back(x);
  endtask

  task automatic fetch(input int g, input logic [AW-1:0] a, input logic [23:0] ba,
                       input logic [IW-1:0] wd, input bit move_addr);
    push_exp(g, ba, wd);
    addr[g] = a;
    req[g]  = 1'b1;
    wait_accept(g);
    req[g] = 1'b0;
    if (move_addr) addr[g] = 12'h7FF;
    wait_drain(g);
    check($sformatf("instr_hold[%0d]", g), instr[g], wd);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit   bad_cs, bad_sck, bad_instr, saw_rdy;

    vecs[0] = '{0, 12'h200, 24'h000400, 16'hA55A};
    vecs[1] = '{0, 12'h000, 24'h000000, 16'h1234};
    vecs[2] = '{0, 12'hFFF, 24'h001FFE, 16'hBEEF};
    vecs[3] = '{1, 12'hFFF, 24'h001FFE, 16'hBEEF};
    vecs[4] = '{1, 12'h200, 24'h000400, 16'hA55A};
    vecs[5] = '{1, 12'h7FF, 24'h000FFE, 16'hC0DE};

    // Reset state, then 50 idle cycles with no request.
    repeat (2) tick();
    check("reset_pins0", {cs_n[0], sck[0], mosi[0], rdy[0], busy[0]}, 5'b10000);
    check("reset_pins1", {cs_n[1], sck[1], mosi[1], rdy[1], busy[1]}, 5'b10000);
    arst = 2'b00;
    {bad_cs, bad_sck, bad_instr, saw_rdy} = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cs_n != 2'b11) bad_cs = 1'b1;
      if (sck != 2'b00) bad_sck = 1'b1;
      if (instr[0] != '0 || instr[1] != '0) bad_instr = 1'b1;
      if (rdy != 2'b00) saw_rdy = 1'b1;
    end
    check("idle_cs_n", bad_cs, 1'b0);
    check("idle_sck", bad_sck, 1'b0);
    check("idle_instr", bad_instr, 1'b0);
    check("idle_ready", saw_rdy, 1'b0);

    for (int i = 0; i < 6; i++)
      fetch(vecs[i].inst, vecs[i].addr, vecs[i].baddr, vecs[i].word, 1'b0);

    // Address must be latched at acceptance.
    fetch(0, 12'h200, 24'h000400, 16'hA55A, 1'b1);

    // Back-to-back: request held, PC advances on flash_ready.
    push_exp(0, 24'h000400, 16'hA55A);
    push_exp(0, 24'h000402, 16'h3C96);
    addr[0] = 12'h200;
    req[0]  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (rdy[0]) break;
    end
    check("b2b_first_ready", rdy[0], 1'b1);
    tick();
    addr[0] = 12'h201;
    wait_accept(0);
    req[0] = 1'b0;
    wait_drain(0);
    check("b2b_cs_gap", 64'(u[0].gap), 64'd2);

    // Reset in the middle of the data phase.
    addr[0] = 12'h200;
    req[0]  = 1'b1;
    wait_accept(0);
    req[0] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (u[0].bitn >= 40) break;
      tick();
    end
    check("abort_reached_data", 64'(u[0].bitn >= 40), 64'd1);
    arst[0] = 1'b1;
    #1;
    check("abort_pins", {cs_n[0], sck[0], busy[0], rdy[0]}, 4'b1000);
    check("abort_instr", instr[0], '0);
    repeat (3) tick();
    arst[0] = 1'b0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (rdy[0]) saw_rdy = 1'b1;
    end
    check("abort_no_ready", saw_rdy, 1'b0);
    fetch(0, 12'h001, 24'h000002, 16'hDEAD, 1'b0);

    check("protocol0", 64'(u[0].viol), 64'd0);
    check("protocol1", 64'(u[1].viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
